// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS main control FSM with memory handshake,
// stall watchdog, sticky error flags and retired-instruction counter.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             MemtoReg_o,
    output logic             RegDst_o,
    output logic             RegWrite_o,
    output logic             ALUSrcA_o,
    output logic             IorD_o,
    output logic             ExtZero_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALUOp_o,
    output logic [1:0]       PCSource_o,
    output logic             pc_en_o,
    output logic [3:0]       state_o,
    output logic             illegal_instr_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] instr_count_o
);
    localparam int SW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, IEXEC = 4'd9,
        IWB = 4'd10, JUMP = 4'd11, ERROR = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
        logic       alu_src_a, iord, ext_zero, pc_write, pc_write_cond;
        logic [1:0] alu_src_b, alu_op, pc_source;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] o);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
            EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_write_cond = 1'b1;
            end
            IEXEC:  begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11;
                c.ext_zero = (o == 6'h0C) || (o == 6'h0D);
            end
            IWB:    begin c.reg_write = 1'b1; c.ext_zero = (o == 6'h0C) || (o == 6'h0D); end
            JUMP:   begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic state_t dispatch(input logic [5:0] o);
        return (o == 6'h23 || o == 6'h2B) ? MEMADR :
               (o == 6'h00) ? EXEC :
               (o == 6'h04 || o == 6'h05) ? BRANCH :
               (o == 6'h08 || o == 6'h0C || o == 6'h0D) ? IEXEC :
               (o == 6'h02) ? JUMP : ERROR;
    endfunction

    state_t           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [5:0]       op_q, op_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d, to_q, to_d;
    logic             mem_wait, timeout, pc_write;
    logic             unused_funct;

    assign unused_funct = ^funct_i;
    assign mem_wait = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !mem_ready_i;
    assign timeout  = (MEM_TIMEOUT > 0) && mem_wait && (stall_q == SW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ill_d   = ill_q;
        to_d    = to_q;
        case (state_q)
            FETCH:  state_d = mem_ready_i ? DECODE : FETCH;
            DECODE: begin
                op_d    = op_i;
                state_d = dispatch(op_i);
                ill_d   = ill_q | (dispatch(op_i) == ERROR);
            end
            MEMADR: state_d = (op_q == 6'h23) ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready_i ? MEMWB : MEMRD;
            MEMWR:  state_d = mem_ready_i ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            IEXEC:  state_d = IWB;
            MEMWB, ALUWB, BRANCH, IWB, JUMP: state_d = FETCH;
            default: state_d = ERROR;
        endcase
        if (timeout) begin
            state_d = ERROR;
            to_d    = 1'b1;
        end
    end

    // stall count restarts whenever the wait ends or the state changes
    assign stall_d = (mem_wait && state_d == state_q) ? stall_q + 1'b1 : '0;
    assign cnt_d   = (state_d == FETCH && state_q != FETCH) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            stall_q <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
            ctrl_q  <= ctrl_of(FETCH, 6'h00);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
            ctrl_q  <= ctrl_of(state_d, op_d);
        end
    end

    assign pc_write = ctrl_q.pc_write | (state_q == FETCH && mem_ready_i);

    assign MemRead_o       = rst & ctrl_q.mem_read;
    assign MemWrite_o      = rst & ctrl_q.mem_write;
    assign IRWrite_o       = rst & (state_q == FETCH) & mem_ready_i;
    assign MemtoReg_o      = rst & ctrl_q.mem_to_reg;
    assign RegDst_o        = rst & ctrl_q.reg_dst;
    assign RegWrite_o      = rst & ctrl_q.reg_write;
    assign ALUSrcA_o       = rst & ctrl_q.alu_src_a;
    assign IorD_o          = rst & ctrl_q.iord;
    assign ExtZero_o       = rst & ctrl_q.ext_zero;
    assign ALUSrcB_o       = rst ? ctrl_q.alu_src_b : 2'b00;
    assign ALUOp_o         = rst ? ctrl_q.alu_op : 2'b00;
    assign PCSource_o      = rst ? ctrl_q.pc_source : 2'b00;
    assign pc_en_o         = rst & (pc_write | (ctrl_q.pc_write_cond & (zero_i ^ (op_q == 6'h05))));
    assign state_o         = rst ? state_q : 4'd0;
    assign illegal_instr_o = rst & ill_q;
    assign mem_timeout_o   = rst & to_q;
    assign instr_count_o   = rst ? cnt_q : '0;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: instruction-level reference model driving directed and
// random instruction streams with random memory stalls through the control FSM.
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0, rst = 1'b0, zero = 1'b0, mem_ready = 1'b1;
    logic [5:0] op = 6'h00, funct = 6'h00;
    logic       MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IorD, ExtZero, pc_en;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       illegal_instr, mem_timeout;
    logic [7:0] instr_count;
    logic [15:0] vec;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .op_i(op), .funct_i(funct), .zero_i(zero), .mem_ready_i(mem_ready),
        .MemRead_o(MemRead), .MemWrite_o(MemWrite), .IRWrite_o(IRWrite), .MemtoReg_o(MemtoReg),
        .RegDst_o(RegDst), .RegWrite_o(RegWrite), .ALUSrcA_o(ALUSrcA), .IorD_o(IorD),
        .ExtZero_o(ExtZero), .ALUSrcB_o(ALUSrcB), .ALUOp_o(ALUOp), .PCSource_o(PCSource),
        .pc_en_o(pc_en), .state_o(state), .illegal_instr_o(illegal_instr),
        .mem_timeout_o(mem_timeout), .instr_count_o(instr_count)
    );

    always #5 clk = ~clk;

    assign vec = {MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IorD, ExtZero,
                  ALUSrcB, ALUOp, PCSource, pc_en};

    int         tests = 0, fails = 0, exp_cnt = 0;
    logic       exp_ill = 1'b0, exp_to = 1'b0;
    logic [5:0] cur_oq = 6'h00;
    logic [5:0] legal [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // expected control vector for a state, taken from the per-state output table
    function automatic logic [15:0] exp_vec(input int st, input logic [5:0] oq, input logic mr, input logic z);
        logic       rd, wr, ir, m2r, rdst, rw, srca, iord, ez, pe;
        logic [1:0] srcb, aop, pcs;
        rd   = st == 0 || st == 3;
        wr   = st == 5;
        ir   = st == 0 && mr;
        m2r  = st == 4;
        rdst = st == 7;
        rw   = st == 4 || st == 7 || st == 10;
        srca = st == 2 || st == 6 || st == 8 || st == 9;
        iord = st == 3 || st == 5;
        ez   = (st == 9 || st == 10) && (oq == 6'h0C || oq == 6'h0D);
        srcb = st == 0 ? 2'd1 : st == 1 ? 2'd3 : (st == 2 || st == 9) ? 2'd2 : 2'd0;
        aop  = st == 6 ? 2'd2 : st == 8 ? 2'd1 : st == 9 ? 2'd3 : 2'd0;
        pcs  = st == 8 ? 2'd1 : st == 11 ? 2'd2 : 2'd0;
        pe   = (st == 0 && mr) || st == 11 || (st == 8 && (oq == 6'h04 ? z : !z));
        return {rd, wr, ir, m2r, rdst, rw, srca, iord, ez, srcb, aop, pcs, pe};
    endfunction

    task automatic step(input logic mr, input logic z, input logic [5:0] o, input int st, input logic [5:0] oq);
        mem_ready = mr;
        zero      = z;
        op        = o;
        funct     = 6'($urandom);
        @(negedge clk);
        chk($sformatf("state(st%0d)", st), 32'(state), 32'(st));
        chk($sformatf("ctrl(st%0d)", st), 32'(vec), 32'(exp_vec(st, oq, mr, z)));
        chk("instr_count", 32'(instr_count), 32'(exp_cnt % 256));
        chk("flags", {30'd0, illegal_instr, mem_timeout}, {30'd0, exp_ill, exp_to});
        @(posedge clk);
        #1;
    endtask

    // one instruction: sf fetch stalls, sm stalls in the data-memory state
    task automatic run_instr(input logic [5:0] o, input logic z, input int sf, input int sm);
        logic [5:0] g;
        g = 6'($urandom);
        repeat (sf) step(1'b0, z, o, 0, cur_oq);
        step(1'b1, z, o, 0, cur_oq);
        step(1'($urandom), z, o, 1, cur_oq);
        cur_oq = o;
        case (o)
            6'h00: begin step(1'($urandom), z, g, 6, o); step(1'($urandom), z, g, 7, o); end
            6'h23: begin
                step(1'($urandom), z, g, 2, o);
                repeat (sm) step(1'b0, z, g, 3, o);
                step(1'b1, z, g, 3, o);
                step(1'($urandom), z, g, 4, o);
            end
            6'h2B: begin
                step(1'($urandom), z, g, 2, o);
                repeat (sm) step(1'b0, z, g, 5, o);
                step(1'b1, z, g, 5, o);
            end
            6'h04, 6'h05: step(1'($urandom), z, g, 8, o);
            6'h08, 6'h0C, 6'h0D: begin step(1'($urandom), z, g, 9, o); step(1'($urandom), z, g, 10, o); end
            6'h02: step(1'($urandom), z, g, 11, o);
            default: begin
                exp_ill = 1'b1;
                step(1'($urandom), z, g, 12, o);
                return;
            end
        endcase
        exp_cnt++;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ctrl", 32'(vec), 32'd0);
            chk("rst_state", 32'(state), 32'd0);
            chk("rst_misc", {22'd0, instr_count, illegal_instr, mem_timeout}, 32'd0);
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        exp_cnt = 0;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        cur_oq  = 6'h00;
    endtask

    initial begin
        do_reset();
        run_instr(6'h00, 1'b0, 0, 0);
        run_instr(6'h23, 1'b0, 0, 0);
        run_instr(6'h2B, 1'b0, 0, 0);
        run_instr(6'h04, 1'b1, 0, 0);
        run_instr(6'h02, 1'b0, 0, 0);
        chk("count_after_5", 32'(instr_count), 32'd5);
        run_instr(6'h04, 1'b0, 0, 0);
        run_instr(6'h05, 1'b0, 0, 0);
        run_instr(6'h23, 1'b0, 0, 3);
        run_instr(6'h0D, 1'b0, 0, 0);
        run_instr(6'h08, 1'b1, 3, 0);
        for (int i = 0; i < 300; i++)
            run_instr(legal[$urandom_range(0, 8)], 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        // sw whose write never completes: watchdog expires after 4 stalled cycles
        run_instr(6'h00, 1'b0, 0, 0);
        step(1'b1, 1'b0, 6'h2B, 0, cur_oq);
        step(1'b1, 1'b0, 6'h2B, 1, cur_oq);
        cur_oq = 6'h2B;
        step(1'b1, 1'b0, 6'h2B, 2, cur_oq);
        repeat (4) step(1'b0, 1'b0, 6'h2B, 5, cur_oq);
        exp_to = 1'b1;
        repeat (3) step(1'($urandom), 1'($urandom), 6'($urandom), 12, cur_oq);
        do_reset();
        run_instr(6'h3F, 1'b0, 1, 0);
        repeat (3) step(1'($urandom), 1'($urandom), 6'($urandom), 12, cur_oq);
        do_reset();
        run_instr(6'h0C, 1'b0, 0, 0);
        run_instr(6'h23, 1'b1, 2, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Parametrised main control FSM for the multicycle MIPS core; next generation of the existing fixed-latency control module.
- Sits between the instruction register decode fields (op, funct) and the datapath muxes and enables.
- Adds over the previous generation: variable-latency memory handshake (mem_ready), a memory-stall watchdog, BNE/ADDI/ANDI/ORI/J support, internal PC-enable generation, a sticky error state, and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive stall cycles in any memory state before error; 0 disables the watchdog.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk in 1: clock.
- rst in 1: synchronous active-low reset.
- op in 6: IR[31:26].
- funct in 6: IR[5:0]; unused, provided for the ALU control.
- zero in 1: ALU zero flag.
- mem_ready in 1: memory completes the current access this cycle.
- MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IorD, ExtZero out 1 each.
- ALUSrcB, ALUOp, PCSource out 2 each.
- pc_en out 1: final PC register enable.
- state out 4: current state encoding.
- illegal_instr out 1: sticky; undefined opcode.
- mem_timeout out 1: sticky; watchdog fired.
- instr_count out CNT_W: instructions retired.

Behaviour:
- Reset: sampled on posedge while rst==0. Sets state=FETCH(0), op_q=0, stall counter=0, instr_count=0 and both error flags=0.
- While rst==0, every output is forced to 0, state output included.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, ERROR 12.
- Outputs are Moore (decoded from state) except IRWrite, PCWrite and pc_en. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stay while !mem_ready; go to DECODE on mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Latch op into op_q. Dispatch on op:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 -> EXEC
  - 0x04 or 0x05 -> BRANCH
  - 0x08, 0x0C or 0x0D -> IEXEC
  - 0x02 -> JUMP
  - anything else -> ERROR, and set illegal_instr.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD if op_q==0x23, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1, held for the whole stall. On mem_ready, next state FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1. Next state FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11 (ALU control decodes op). ExtZero=1 when op_q is 0x0C or 0x0D. Next state IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. ExtZero is held as in IEXEC. Next state FETCH.
- JUMP: PCSource=10, PCWrite=1. Next state FETCH.
- pc_en = PCWrite | (PCWriteCond & (zero ^ (op_q==0x05))).
- ERROR: all control outputs 0, holds until reset. illegal_instr and mem_timeout stay set until reset.
- Watchdog (memory-wait states FETCH, MEMRD, MEMWR):
  - Stall counter increments each cycle in the state with mem_ready==0; clears on mem_ready or on any state change.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 with mem_ready still 0, next state is ERROR and mem_timeout is set.
  - mem_ready==1 on that same cycle wins: normal transition, no error.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, IWB or JUMP. It wraps modulo 2^CNT_W.
- Latency with zero-wait memory: R-type 4 cycles, LW 5, SW 4, BEQ/BNE 3, ADDI/ANDI/ORI 4, J 3.

Test Plan:
- Reset with rst=0 held for 2 cycles, mem_ready=1 -> all outputs 0 during reset. First cycle after release: state=0, MemRead=1, IRWrite=1, pc_en=1.
- mem_ready=1, stream add/lw/sw/beq/j (op 00, 23, 2B, 04, 02) -> state sequences 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,11. instr_count=5.
- BEQ with zero=0, then BNE (op 05) with zero=0 -> pc_en=0 in BRANCH for BEQ; pc_en=1 in BRANCH for BNE.
- lw with mem_ready low for 3 cycles in MEMRD -> MemRead and IorD held; state stays 3 for 4 cycles, then goes to 4.
- MEM_TIMEOUT=4, mem_ready stuck 0 in MEMWR -> state=12 after 4 cycles, mem_timeout=1, MemWrite=0 in ERROR. rst pulse clears the flag.
- op=0x3F in DECODE -> state=12, illegal_instr=1, all controls 0 until reset. ori (op 0D) -> ExtZero=1 in states 9 and 10, RegWrite=1 in state 10.
